// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack (LIFO of DEPTH entries).
// Define PC_STACK_CIRCULAR_EN to make a call while full overwrite the oldest entry.
module pc_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     load,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     flag_clr,
  input  logic [WIDTH-1:0]         in,
  output logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         tos,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [AW-1:0]    r_wr_idx;
  logic [AW:0]      r_depth;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_ret_addr;
  logic             w_do_load;
  logic             w_do_call;
  logic             w_do_ret;
  logic             w_do_inc;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_pc_next;

  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == (AW+1)'(DEPTH));
  assign w_top_idx  = r_wr_idx - AW'(1);
  assign w_ret_addr = r_pc + WIDTH'(1);

  // Only the highest-priority asserted command acts: load > call > ret > inc.
  always_comb begin
    w_do_load = load;
    w_do_call = !load && call;
    w_do_ret  = !load && !call && ret;
    w_do_inc  = !load && !call && !ret && inc;
  end

`ifdef PC_STACK_CIRCULAR_EN
  assign w_push = w_do_call;
`else
  assign w_push = w_do_call && !w_full;
`endif
  assign w_pop = w_do_ret && !w_empty;

  always_comb begin
    w_pc_next = r_pc;
    if (w_do_load || w_do_call) w_pc_next = in;
    else if (w_pop)             w_pc_next = r_stack[w_top_idx];
    else if (w_do_inc)          w_pc_next = r_pc + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_wr_idx <= '0;
      r_depth  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_push) begin
        r_wr_idx <= r_wr_idx + AW'(1);
        if (!w_full) r_depth <= r_depth + (AW+1)'(1);
      end else if (w_pop) begin
        r_wr_idx <= w_top_idx;
        r_depth  <= r_depth - (AW+1)'(1);
      end
      if (w_do_call && w_full)      r_ovf <= 1'b1;
      else if (flag_clr)            r_ovf <= 1'b0;
      if (w_do_ret && w_empty)      r_unf <= 1'b1;
      else if (flag_clr)            r_unf <= 1'b0;
    end
  end

  // Storage is deliberately not reset; a held reset still blocks writes.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[r_wr_idx] <= w_ret_addr;
  end

  assign out       = r_pc;
  assign tos       = w_empty ? '0 : r_stack[w_top_idx];
  assign depth     = r_depth;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (16-bit/8-deep and 8-bit instances).
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc, load, call, ret, flag_clr;
  logic [15:0] din;
  logic [15:0] out, tos;
  logic [3:0]  depth;
  logic        empty, full, overflow, underflow;

  logic        inc8, load8, call8, ret8, fclr8;
  logic [7:0]  din8;
  logic [7:0]  out8, tos8;
  logic [3:0]  depth8;
  logic        empty8, full8, ovf8, unf8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_stack #(.WIDTH(16), .DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .inc(inc), .load(load), .call(call), .ret(ret),
    .flag_clr(flag_clr), .in(din), .out(out), .tos(tos), .depth(depth),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  pc_stack #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .inc(inc8), .load(load8), .call(call8), .ret(ret8),
    .flag_clr(fclr8), .in(din8), .out(out8), .tos(tos8), .depth(depth8),
    .empty(empty8), .full(full8), .overflow(ovf8), .underflow(unf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one command for a single edge, then sample 1 time unit after that edge.
  task automatic cmd(input logic l, input logic c, input logic r, input logic i,
                     input logic fc, input logic [15:0] d);
    load = l; call = c; ret = r; inc = i; flag_clr = fc; din = d;
    @(posedge clk);
    #1;
    load = 0; call = 0; ret = 0; inc = 0; flag_clr = 0;
  endtask

  initial begin
    inc = 0; load = 0; call = 0; ret = 0; flag_clr = 0; din = '0;
    inc8 = 0; load8 = 0; call8 = 0; ret8 = 0; fclr8 = 0; din8 = '0;
    reset = 1'b1;
    #2;
    chk("rst_out",   32'(out), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_unf",   32'(underflow), 0);
    chk("rst_tos",   32'(tos), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Mid-sequence asynchronous reset at out = 5 with one entry on the stack
    cmd(0, 1, 0, 0, 0, 16'h0004);
    cmd(0, 0, 0, 1, 0, 16'h0000);
    chk("pre_rst_out",   32'(out), 32'h5);
    chk("pre_rst_depth", 32'(depth), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_out",   32'(out), 0);
    chk("async_rst_depth", 32'(depth), 0);
    chk("async_rst_tos",   32'(tos), 0);
    #3;
    reset = 1'b0;
    repeat (3) cmd(0, 0, 0, 1, 0, 16'h0000);
    chk("inc3", 32'(out), 32'h3);
    cmd(1, 0, 0, 0, 0, 16'hFFFF);
    chk("load_ffff", 32'(out), 32'hFFFF);
    cmd(0, 0, 0, 1, 0, 16'h0000);
    chk("inc_wrap", 32'(out), 32'h0);

    // Nested call/return
    cmd(1, 0, 0, 0, 0, 16'h0010);
    cmd(0, 1, 0, 0, 0, 16'h0100);
    chk("call1_out",   32'(out), 32'h0100);
    chk("call1_tos",   32'(tos), 32'h0011);
    chk("call1_depth", 32'(depth), 1);
    cmd(0, 1, 0, 0, 0, 16'h0200);
    chk("call2_tos",   32'(tos), 32'h0101);
    chk("call2_depth", 32'(depth), 2);
    cmd(0, 0, 1, 0, 0, 16'h0000);
    chk("ret1_out", 32'(out), 32'h0101);
    chk("ret1_tos", 32'(tos), 32'h0011);
    cmd(0, 0, 1, 0, 0, 16'h0000);
    chk("ret2_out",   32'(out), 32'h0011);
    chk("ret2_empty", 32'(empty), 1);
    chk("ret2_tos",   32'(tos), 0);

    // Priority
    cmd(1, 1, 0, 1, 0, 16'h0300);
    chk("prio_load_out",   32'(out), 32'h0300);
    chk("prio_load_depth", 32'(depth), 0);
    cmd(0, 1, 1, 0, 0, 16'h0400);
    chk("prio_call_out",   32'(out), 32'h0400);
    chk("prio_call_depth", 32'(depth), 1);
    chk("prio_call_tos",   32'(tos), 32'h0301);
    cmd(0, 0, 1, 1, 0, 16'h0000);
    chk("prio_ret_out",   32'(out), 32'h0301);
    chk("prio_ret_depth", 32'(depth), 0);

    // Underflow and sticky clear
    cmd(1, 0, 0, 0, 0, 16'h0042);
    cmd(0, 0, 1, 0, 0, 16'h0000);
    chk("unf_out",   32'(out), 32'h0042);
    chk("unf_flag",  32'(underflow), 1);
    chk("unf_depth", 32'(depth), 0);
    cmd(0, 0, 0, 0, 1, 16'h0000);
    chk("unf_clr", 32'(underflow), 0);
    cmd(0, 0, 1, 0, 1, 16'h0000);
    chk("unf_over_clr", 32'(underflow), 1);
    cmd(0, 0, 0, 0, 1, 16'h0000);
    chk("unf_clr2", 32'(underflow), 0);

    // Overflow: return addresses are 0x1001, then 0x2001 + 0x10*(k-1) for call k
    cmd(1, 0, 0, 0, 0, 16'h1000);
    for (int k = 0; k < 8; k++) cmd(0, 1, 0, 0, 0, 16'(32'h2000 + k * 32'h10));
    chk("fill_full",  32'(full), 1);
    chk("fill_ovf",   32'(overflow), 0);
    chk("fill_tos",   32'(tos), 32'h2061);
    cmd(0, 1, 0, 0, 0, 16'h2080);
    chk("ovf_out",   32'(out), 32'h2080);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_full",  32'(full), 1);
    chk("ovf_depth", 32'(depth), 8);
`ifdef PC_STACK_CIRCULAR_EN
    chk("ovf_tos", 32'(tos), 32'h2071);
    for (int k = 8; k >= 1; k--) begin
      cmd(0, 0, 1, 0, 0, 16'h0000);
      chk("ovf_ret", 32'(out), 32'h2001 + (k - 1) * 32'h10);
    end
`else
    chk("ovf_tos", 32'(tos), 32'h2061);
    for (int k = 7; k >= 1; k--) begin
      cmd(0, 0, 1, 0, 0, 16'h0000);
      chk("ovf_ret", 32'(out), 32'h2001 + (k - 1) * 32'h10);
    end
    cmd(0, 0, 1, 0, 0, 16'h0000);
    chk("ovf_ret_last", 32'(out), 32'h1001);
`endif
    chk("ovf_drain_empty", 32'(empty), 1);
    chk("ovf_drain_unf",   32'(underflow), 0);
    cmd(0, 0, 0, 0, 1, 16'h0000);
    chk("ovf_clr", 32'(overflow), 0);

    // 8-bit instance: return address wraps
    load8 = 1; din8 = 8'hFF;
    @(posedge clk); #1;
    load8 = 0; call8 = 1; din8 = 8'h10;
    @(posedge clk); #1;
    call8 = 0;
    chk("w8_out",   32'(out8), 32'h10);
    chk("w8_tos",   32'(tos8), 32'h00);
    chk("w8_depth", 32'(depth8), 1);
    ret8 = 1;
    @(posedge clk); #1;
    ret8 = 0;
    chk("w8_ret", 32'(out8), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
